auto_navigator: RTL and testbench

AUTO_NAVIGATOR -- requirements
Module: auto_navigator

---
 rtl/nav_pkg.sv | 41 ++++
 rtl/nav_policy.sv | 39 +++
 rtl/auto_navigator.sv | 145 ++++++++++++++
 tb/tb_auto_navigator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nav_pkg.sv
// nav_pkg -- shared encodings for the auto navigator.
// Drive-FSM state codes, navigator state encoding and one-hot command codes.
package nav_pkg;

    // Drive FSM state codes seen on the 'state' input
    localparam logic [1:0] DRV_WAITING  = 2'b00;
    localparam logic [1:0] DRV_FORWARD  = 2'b01;
    localparam logic [1:0] DRV_TURNING  = 2'b10;
    localparam logic [1:0] DRV_COOLDOWN = 2'b11;

    // global_state code meaning the car is in autonomous mode
    localparam logic [1:0] GS_AUTO = 2'b10;

    // Navigator states
    typedef enum logic [1:0] {
        NAV_IDLE    = 2'b00,
        NAV_SETTLE  = 2'b01,
        NAV_ISSUE   = 2'b10,
        NAV_RELEASE = 2'b11
    } nav_state_t;

    // One-hot command word: bit0 left, bit1 right, bit2 straight, bit3 back
    typedef logic [3:0] cmd_t;

    localparam int CMD_BIT_LEFT     = 0;
    localparam int CMD_BIT_RIGHT    = 1;
    localparam int CMD_BIT_STRAIGHT = 2;
    localparam int CMD_BIT_BACK     = 3;

    localparam cmd_t CMD_NONE     = 4'b0000;
    localparam cmd_t CMD_LEFT     = 4'b0001;
    localparam cmd_t CMD_RIGHT    = 4'b0010;
    localparam cmd_t CMD_STRAIGHT = 4'b0100;
    localparam cmd_t CMD_BACK     = 4'b1000;

    // True when the drive FSM is parked and willing to accept a new command
    function automatic logic drv_is_waiting(input logic [1:0] drv);
        return drv == DRV_WAITING;
    endfunction

endpackage

// File: rtl/nav_policy.sv
// nav_policy -- combinational detector-to-command priority encoder.
// detector[0]=1 front blocked, detector[1]=0 left open, detector[2]=0 right open.
// Define NAV_LEFT_HAND_EN to follow the left-hand wall instead of the right.
import nav_pkg::*;

module nav_policy (
    input  logic [2:0] detector,
    output cmd_t       cmd
);

    logic front_clear;
    logic left_open;
    logic right_open;

    assign front_clear = ~detector[0];
    assign left_open   = ~detector[1];
    assign right_open  = ~detector[2];

    // Wall-following priority; back only when every direction is blocked
    always_comb begin
        cmd = CMD_BACK;
`ifdef NAV_LEFT_HAND_EN
        if (left_open)
            cmd = CMD_LEFT;
        else if (front_clear)
            cmd = CMD_STRAIGHT;
        else if (right_open)
            cmd = CMD_RIGHT;
`else
        if (right_open)
            cmd = CMD_RIGHT;
        else if (front_clear)
            cmd = CMD_STRAIGHT;
        else if (left_open)
            cmd = CMD_LEFT;
`endif
    end

endmodule

// File: rtl/auto_navigator.sv
// auto_navigator -- debounced obstacle-driven command generator for the drive FSM.
// Waits for the drive FSM to sit in WAITING, requires the detector to hold still
// for SETTLE_TICKS ticks, then holds one command until the drive FSM reacts or
// HOLD_TIMEOUT ticks pass. Policy selection: NAV_LEFT_HAND_EN (see nav_policy).
import nav_pkg::*;

module auto_navigator #(
    parameter int SETTLE_TICKS = 5,
    parameter int HOLD_TIMEOUT = 25
) (
    input  logic       clk_20ms,
    input  logic       rst,
    input  logic       power,
    input  logic [1:0] global_state,
    input  logic [1:0] state,
    input  logic [3:0] detector,
    output logic       left,
    output logic       right,
    output logic       straight,
    output logic       back,
    output logic       nav_busy,
    output logic       timeout_pulse,
    output logic [7:0] decision_cnt
);

    localparam int SC_W = $clog2(SETTLE_TICKS + 1);
    localparam int HC_W = $clog2(HOLD_TIMEOUT + 1);

    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_TICKS - 1);
    localparam logic [HC_W-1:0] HOLD_LAST   = HC_W'(HOLD_TIMEOUT - 1);

    nav_state_t      nav_st;
    cmd_t            cmd;
    cmd_t            policy_cmd;
    logic [2:0]      sample;
    logic [SC_W-1:0] settle_cnt;
    logic [HC_W-1:0] hold_cnt;

    logic active;
    logic waiting;
    logic det_changed;
    logic det_unused;

    // Bit 3 of the detector carries no sensor
    assign det_unused  = detector[3];

    assign active      = power && (global_state == GS_AUTO);
    assign waiting     = drv_is_waiting(state);
    assign det_changed = (detector[2:0] != sample);

    nav_policy u_policy (
        .detector (detector[2:0]),
        .cmd      (policy_cmd)
    );

    assign left     = cmd[CMD_BIT_LEFT];
    assign right    = cmd[CMD_BIT_RIGHT];
    assign straight = cmd[CMD_BIT_STRAIGHT];
    assign back     = cmd[CMD_BIT_BACK];

    // Busy while a decision is being debounced or a command is being held
    assign nav_busy = (nav_st == NAV_SETTLE) || (nav_st == NAV_ISSUE);

    // Navigator FSM: leaving auto mode or power beats every other transition
    always_ff @(posedge clk_20ms) begin
        if (rst) begin
            nav_st        <= NAV_IDLE;
            cmd           <= CMD_NONE;
            timeout_pulse <= 1'b0;
            decision_cnt  <= 8'd0;
            settle_cnt    <= '0;
            hold_cnt      <= '0;
            sample        <= 3'b000;
        end else begin
            timeout_pulse <= 1'b0;
            if (!active) begin
                nav_st     <= NAV_IDLE;
                cmd        <= CMD_NONE;
                settle_cnt <= '0;
                hold_cnt   <= '0;
            end else begin
                case (nav_st)
                    NAV_IDLE: begin
                        cmd <= CMD_NONE;
                        if (waiting) begin
                            nav_st     <= NAV_SETTLE;
                            settle_cnt <= '0;
                            sample     <= detector[2:0];
                        end
                    end

                    NAV_SETTLE: begin
                        if (!waiting) begin
                            nav_st     <= NAV_IDLE;
                            settle_cnt <= '0;
                        end else if (det_changed) begin
                            // Any movement restarts the debounce window
                            sample     <= detector[2:0];
                            settle_cnt <= '0;
                        end else if (settle_cnt == SETTLE_LAST) begin
                            nav_st       <= NAV_ISSUE;
                            cmd          <= policy_cmd;
                            hold_cnt     <= '0;
                            settle_cnt   <= '0;
                            decision_cnt <= decision_cnt + 8'd1;
                        end else begin
                            settle_cnt <= settle_cnt + SC_W'(1);
                        end
                    end

                    NAV_ISSUE: begin
                        // Drive FSM reacting wins over a coincident timeout
                        if (!waiting) begin
                            nav_st   <= NAV_RELEASE;
                            cmd      <= CMD_NONE;
                            hold_cnt <= '0;
                        end else if (hold_cnt == HOLD_LAST) begin
                            nav_st        <= NAV_SETTLE;
                            cmd           <= CMD_NONE;
                            timeout_pulse <= 1'b1;
                            hold_cnt      <= '0;
                            settle_cnt    <= '0;
                            sample        <= detector[2:0];
                        end else begin
                            hold_cnt <= hold_cnt + HC_W'(1);
                        end
                    end

                    NAV_RELEASE: begin
                        // Wait for the drive FSM to be moving forward again
                        cmd <= CMD_NONE;
                        if (state == DRV_FORWARD)
                            nav_st <= NAV_IDLE;
                    end

                    default: begin
                        nav_st <= NAV_IDLE;
                        cmd    <= CMD_NONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_auto_navigator.sv
// tb_auto_navigator -- directed plus randomized checks of auto_navigator
// against a tick-timestamp reference model.
module tb_auto_navigator;

    localparam int ST = 5;
    localparam int HT = 25;

    localparam int P_IDLE    = 0;
    localparam int P_SETTLE  = 1;
    localparam int P_ISSUE   = 2;
    localparam int P_RELEASE = 3;

    logic       clk_20ms = 1'b0;
    logic       rst = 1'b1;
    logic       power = 1'b0;
    logic [1:0] global_state = 2'b00;
    logic [1:0] state = 2'b00;
    logic [3:0] detector = 4'b0000;
    logic       left, right, straight, back, nav_busy, timeout_pulse;
    logic [7:0] decision_cnt;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    auto_navigator #(.SETTLE_TICKS(ST), .HOLD_TIMEOUT(HT)) dut (
        .clk_20ms      (clk_20ms),
        .rst           (rst),
        .power         (power),
        .global_state  (global_state),
        .state         (state),
        .detector      (detector),
        .left          (left),
        .right         (right),
        .straight      (straight),
        .back          (back),
        .nav_busy      (nav_busy),
        .timeout_pulse (timeout_pulse),
        .decision_cnt  (decision_cnt)
    );

    always #10 clk_20ms = ~clk_20ms;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    endtask

    // Command word as {left,right,straight,back}
    function automatic logic [3:0] policy(input logic [3:0] d);
        logic fc, lo, ro;
        fc = !d[0];
        lo = !d[1];
        ro = !d[2];
`ifdef NAV_LEFT_HAND_EN
        if (lo) return 4'b1000;
        if (fc) return 4'b0010;
        if (ro) return 4'b0100;
        return 4'b0001;
`else
        if (ro) return 4'b0100;
        if (fc) return 4'b0010;
        if (lo) return 4'b1000;
        return 4'b0001;
`endif
    endfunction

    // Reference model: debounce and hold expressed as elapsed ticks since a timestamp
    int         tick = 0;
    int         ph = P_IDLE;
    int         stable_since = 0;
    int         issued_at = 0;
    logic [2:0] m_sample = 3'b000;
    logic [3:0] m_cmd = 4'b0000;
    logic       m_to = 1'b0;
    logic [7:0] m_cnt = 8'd0;

    initial forever begin
        @(posedge clk_20ms);
        tick++;
        m_to = 1'b0;
        if (rst) begin
            ph = P_IDLE; m_cmd = 4'b0000; m_cnt = 8'd0;
        end else if (!(power && global_state == 2'b10)) begin
            ph = P_IDLE; m_cmd = 4'b0000;
        end else begin
            case (ph)
                P_IDLE: begin
                    m_cmd = 4'b0000;
                    if (state == 2'b00) begin
                        ph = P_SETTLE; m_sample = detector[2:0]; stable_since = tick;
                    end
                end
                P_SETTLE: begin
                    if (state != 2'b00) ph = P_IDLE;
                    else if (detector[2:0] != m_sample) begin
                        m_sample = detector[2:0]; stable_since = tick;
                    end else if (tick - stable_since == ST) begin
                        ph = P_ISSUE; m_cmd = policy(detector);
                        m_cnt = 8'((int'(m_cnt) + 1) % 256); issued_at = tick;
                    end
                end
                P_ISSUE: begin
                    if (state != 2'b00) begin
                        ph = P_RELEASE; m_cmd = 4'b0000;
                    end else if (tick - issued_at == HT) begin
                        ph = P_SETTLE; m_cmd = 4'b0000; m_to = 1'b1;
                        m_sample = detector[2:0]; stable_since = tick;
                    end
                end
                default: begin
                    m_cmd = 4'b0000;
                    if (state == 2'b01) ph = P_IDLE;
                end
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model
    initial forever begin
        @(negedge clk_20ms);
        if (chk_en)
            check("cycle", {18'd0, left, right, straight, back, nav_busy, timeout_pulse, decision_cnt},
                  {18'd0, m_cmd, (ph == P_SETTLE || ph == P_ISSUE), m_to, m_cnt});
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk_20ms);
    endtask

    initial begin
        rst = 1'b1; power = 1'b1; global_state = 2'b10; state = 2'b00; detector = 4'b0000;
        ticks(3);
        chk_en = 1'b1;
        check("reset_outputs", {26'd0, left, right, straight, back, nav_busy, timeout_pulse}, 32'd0);
        check("reset_cnt", {24'd0, decision_cnt}, 32'd0);

        // Steady 0011: right open -> right five ticks after SETTLE entry
        rst = 1'b0; detector = 4'b0011;
        ticks(1);
        check("settle_entry_busy", {31'd0, nav_busy}, 32'd1);
        ticks(4);
        check("pre_decision", {28'd0, left, right, straight, back}, 32'd0);
        ticks(1);
        check("decision_right", {28'd0, left, right, straight, back}, 32'b0100);
        check("decision_cnt_1", {24'd0, decision_cnt}, 32'd1);
        ticks(24);
        check("hold_right", {31'd0, right}, 32'd1);
        ticks(1);
        check("timeout", {29'd0, right, timeout_pulse, nav_busy}, 32'b011);
        ticks(1);
        check("pulse_one_tick", {31'd0, timeout_pulse}, 32'd0);

        // Detector change at tick 3 of SETTLE restarts the window
        ticks(1);
        detector = 4'b0111;
        ticks(5);
        check("restart_no_cmd", {31'd0, back}, 32'd0);
        ticks(1);
        check("all_blocked_back", {28'd0, left, right, straight, back}, 32'b0001);
        check("decision_cnt_2", {24'd0, decision_cnt}, 32'd2);

        // Detector moves while held; then drive FSM reacts exactly on the timeout tick
        ticks(10);
        detector = 4'b0000;
        ticks(14);
        check("held_despite_detector", {31'd0, back}, 32'd1);
        state = 2'b10;
        ticks(1);
        check("release_no_pulse", {26'd0, left, right, straight, back, nav_busy, timeout_pulse}, 32'd0);

        // Policy on 0001 (right and left open), then leave auto mode mid-ISSUE
        state = 2'b01;
        ticks(1);
        state = 2'b00; detector = 4'b0001;
        ticks(6);
`ifdef NAV_LEFT_HAND_EN
        check("policy_0001", {28'd0, left, right, straight, back}, 32'b1000);
`else
        check("policy_0001", {28'd0, left, right, straight, back}, 32'b0100);
`endif
        global_state = 2'b01;
        ticks(1);
        check("inactive_drops_cmd", {27'd0, left, right, straight, back, nav_busy}, 32'd0);

        // Reset mid-ISSUE
        global_state = 2'b10;
        ticks(6);
        check("issue_before_rst", {31'd0, nav_busy}, 32'd1);
        rst = 1'b1;
        ticks(1);
        check("rst_drops_all", {19'd0, left, right, straight, back, nav_busy, decision_cnt}, 32'd0);
        rst = 1'b0;

        // decision_cnt wrap via quick ISSUE -> RELEASE -> IDLE loops
        for (int i = 0; i < 255; i++) begin
            state = 2'b00; ticks(6);
            state = 2'b10; ticks(1);
            state = 2'b01; ticks(1);
        end
        check("cnt_255", {24'd0, decision_cnt}, 32'd255);
        state = 2'b00;
        ticks(6);
        check("cnt_wrap", {24'd0, decision_cnt}, 32'd0);

        // Randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            power = ($urandom_range(0, 99) != 0);
            global_state = ($urandom_range(0, 49) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            if ($urandom_range(0, 19) == 0)
                state = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                detector = {1'b0, 3'($urandom_range(0, 7))};
            ticks(1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
